// File: rtl/ec_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ec_ctrl_pkg
// Shared definitions for the accumulator-processor control unit:
//   - opcode encodings of the 3-bit IR field (OP_LOAD .. OP_HALT)
//   - accumulator source select encodings (ASEL_ADD, ASEL_IN, ASEL_MEM)
//   - FSM state enumeration, 4-bit encoding (codes 12..15 are illegal)
// ---------------------------------------------------------------------------
package ec_ctrl_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_INPUT = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] ASEL_ADD = 2'b00;
    localparam logic [1:0] ASEL_IN  = 2'b01;
    localparam logic [1:0] ASEL_MEM = 2'b10;

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd3,
        S_STORE  = 4'd4,
        S_ADD    = 4'd5,
        S_SUB    = 4'd6,
        S_INPUT  = 4'd7,
        S_INREL  = 4'd8,
        S_JZ     = 4'd9,
        S_JPOS   = 4'd10,
        S_HALT   = 4'd11
    } state_e;

endpackage : ec_ctrl_pkg

// File: rtl/control_unit_fsm_instr_counter.sv
// ---------------------------------------------------------------------------
// instr_counter
// CNT_W-bit wrapping up-counter used to count fetched instructions.
// Ports:
//   clk   : rising-edge clock
//   clr_n : asynchronous active-low clear (count returns to 0 immediately)
//   inc   : count up by one on this edge
//   count : registered count value, wraps 2^CNT_W-1 -> 0
// ---------------------------------------------------------------------------
module instr_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;

    // Counter register: async clear, natural modulo-2^CNT_W wrap on increment.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count_r <= '0;
        end else if (inc) begin
            count_r <= count_r + CNT_W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule : instr_counter

// File: rtl/control_unit_fsm.sv
// ---------------------------------------------------------------------------
// control_unit_fsm
// Fetch / decode / execute sequencer for the 8-bit accumulator processor.
// Drives the datapath strobes from the opcode and the accumulator flags,
// handles the Enter handshake of INPUT and parks the machine in HALT.
//
// Optional feature macro: INSTR_COUNT_EN
//   defined   -> parameter CNT_W and output InstrCount (fetched-instruction
//                count, incremented on every edge leaving FETCH, wraps)
//   undefined -> neither the parameter, the port nor the counter exist
//
// Ports:
//   Clock   : rising-edge clock
//   Reset   : asynchronous active-low reset (state -> START, outputs -> 0)
//   IR      : 3-bit opcode
//   Aeq0    : accumulator == 0
//   Apos    : accumulator > 0
//   Enter   : operator strobe for INPUT (level)
//   IRload, JMPmux, PCload, Meminst, MemWr, Asel[1:0], Aload, Sub : strobes
//   Halt    : machine halted
//   InstrCount [CNT_W-1:0] : fetched-instruction count (INSTR_COUNT_EN only)
//
// Outputs are decoded straight from the state register so that an
// asynchronous reset drops every strobe the same instant. Aload (INPUT) and
// PCload (JZ/JPOS) additionally follow Enter / the flags combinationally.
// ---------------------------------------------------------------------------
module control_unit_fsm
    import ec_ctrl_pkg::*;
`ifdef INSTR_COUNT_EN
#(
    parameter int CNT_W = 8
)
`endif
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic [2:0] IR,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic       Enter,
    output logic       IRload,
    output logic       JMPmux,
    output logic       PCload,
    output logic       Meminst,
    output logic       MemWr,
    output logic [1:0] Asel,
    output logic       Aload,
    output logic       Sub,
    output logic       Halt
`ifdef INSTR_COUNT_EN
    ,
    output logic [CNT_W-1:0] InstrCount
`endif
);

    state_e state_r;
    state_e next_state_s;

    // State register with asynchronous reset into START.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r <= S_START;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state selection and strobe decode; every output defaults to 0.
    always_comb begin
        next_state_s = S_START;
        IRload       = 1'b0;
        JMPmux       = 1'b0;
        PCload       = 1'b0;
        Meminst      = 1'b0;
        MemWr        = 1'b0;
        Asel         = ASEL_ADD;
        Aload        = 1'b0;
        Sub          = 1'b0;
        Halt         = 1'b0;
        case (state_r)
            S_START: begin
                next_state_s = S_FETCH;
            end
            S_FETCH: begin
                IRload       = 1'b1;
                PCload       = 1'b1;
                next_state_s = S_DECODE;
            end
            S_DECODE: begin
                Meminst = 1'b1;
                case (IR)
                    OP_LOAD:  next_state_s = S_LOAD;
                    OP_STORE: next_state_s = S_STORE;
                    OP_ADD:   next_state_s = S_ADD;
                    OP_SUB:   next_state_s = S_SUB;
                    OP_INPUT: next_state_s = S_INPUT;
                    OP_JZ:    next_state_s = S_JZ;
                    OP_JPOS:  next_state_s = S_JPOS;
                    OP_HALT:  next_state_s = S_HALT;
                    default:  next_state_s = S_START;
                endcase
            end
            S_LOAD: begin
                Meminst      = 1'b1;
                Asel         = ASEL_MEM;
                Aload        = 1'b1;
                next_state_s = S_FETCH;
            end
            S_STORE: begin
                Meminst      = 1'b1;
                MemWr        = 1'b1;
                next_state_s = S_FETCH;
            end
            S_ADD: begin
                Meminst      = 1'b1;
                Asel         = ASEL_ADD;
                Aload        = 1'b1;
                next_state_s = S_FETCH;
            end
            S_SUB: begin
                Meminst      = 1'b1;
                Asel         = ASEL_ADD;
                Aload        = 1'b1;
                Sub          = 1'b1;
                next_state_s = S_FETCH;
            end
            S_INPUT: begin
                // Capture happens in the cycle Enter is seen high; INREL then
                // waits for release so one press cannot feed two INPUTs.
                Asel  = ASEL_IN;
                Aload = Enter;
                if (Enter) begin
                    next_state_s = S_INREL;
                end else begin
                    next_state_s = S_INPUT;
                end
            end
            S_INREL: begin
                if (Enter) begin
                    next_state_s = S_INREL;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_JZ: begin
                JMPmux       = 1'b1;
                PCload       = Aeq0;
                next_state_s = S_FETCH;
            end
            S_JPOS: begin
                JMPmux       = 1'b1;
                PCload       = Apos;
                next_state_s = S_FETCH;
            end
            S_HALT: begin
                Halt         = 1'b1;
                next_state_s = S_HALT;
            end
            default: begin
                // Illegal encodings recover through START with no strobes.
                next_state_s = S_START;
            end
        endcase
    end

`ifdef INSTR_COUNT_EN
    logic fetch_s;

    // Every edge out of FETCH retires one fetch; HALT never reaches FETCH
    // again, so the count freezes there.
    assign fetch_s = (state_r == S_FETCH);

    instr_counter #(
        .CNT_W (CNT_W)
    ) u_instr_counter (
        .clk   (Clock),
        .clr_n (Reset),
        .inc   (fetch_s),
        .count (InstrCount)
    );
`endif

endmodule : control_unit_fsm
